// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: standard mode sets, scan phase type and axis helpers.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package vga_pkg;

  // One axis of a timing mode, in pixels (horizontal) or lines (vertical).
  typedef struct packed {
    logic [10:0] active;
    logic [10:0] front;
    logic [10:0] pulse;
    logic [10:0] back;
  } axis_t;

  typedef struct packed {
    axis_t h;
    axis_t v;
    logic  hsync_pol;
    logic  vsync_pol;
  } timing_t;

  localparam timing_t VGA_640x480_60 = '{
    h: '{active: 11'd640, front: 11'd16, pulse: 11'd96, back: 11'd48},
    v: '{active: 11'd480, front: 11'd10, pulse: 11'd2,  back: 11'd33},
    hsync_pol: 1'b0,
    vsync_pol: 1'b0
  };

  localparam timing_t VGA_1024x768_60 = '{
    h: '{active: 11'd1024, front: 11'd24, pulse: 11'd136, back: 11'd160},
    v: '{active: 11'd768,  front: 11'd3,  pulse: 11'd6,   back: 11'd29},
    hsync_pol: 1'b0,
    vsync_pol: 1'b0
  };

  // Scan phases in the order a counter walks through them.
  typedef enum logic [1:0] {ACTIVE, FRONT, PULSE, BACK} phase_e;

  // Total cycles (or lines) per period of one axis.
  function automatic int unsigned axis_total(int unsigned active, int unsigned front,
                                             int unsigned pulse, int unsigned back);
    return active + front + pulse + back;
  endfunction

  // Phase of a counter given the cumulative end of each of the first three phases.
  function automatic phase_e phase_of(logic [11:0] cnt, logic [11:0] active_end,
                                      logic [11:0] front_end, logic [11:0] pulse_end);
    if (cnt < active_end)     return ACTIVE;
    else if (cnt < front_end) return FRONT;
    else if (cnt < pulse_end) return PULSE;
    else                      return BACK;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a per-bit reset value; depth 0 is a plain wire.
// Latency: DEPTH cycles.
// Backpressure: none, advances every clock.
module vga_delay_line #(
  parameter int               DEPTH   = 1,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one slot per clock; reset loads the idle pattern into every slot.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_scan_gen.sv
// VGA scan generator: sync, data-enable, window coordinates and border colour.
// Latency: FETCH_LAT+1 cycles from counter position to output pins.
// Backpressure: none, one pixel per clock, no stall.
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_PULSE   = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_PULSE   = 2,
  parameter int unsigned V_BACK    = 33,
  parameter logic        HSYNC_POL = 1'b0,
  parameter logic        VSYNC_POL = 1'b0,
  parameter int unsigned COLOR_W   = 4,
  parameter int unsigned FETCH_LAT = 1,
  parameter int unsigned WIN_X0    = 76,
  parameter int unsigned WIN_Y0    = 100,
  parameter int unsigned WIN_W     = 488,
  parameter int unsigned WIN_H     = 280,
  parameter logic [3*COLOR_W-1:0] BORDER_COLOR = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3*COLOR_W-1:0] color_in,
  output logic [10:0]          next_x,
  output logic [10:0]          next_y,
  output logic                 next_valid,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 frame_start,
  output logic                 line_start
);

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FRONT, H_PULSE, H_BACK);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FRONT, V_PULSE, V_BACK);

  if (WIN_X0 + WIN_W > H_ACTIVE) begin : g_err_win_x
    $error("vga_scan_gen: window extends past horizontal active area");
  end
  if (WIN_Y0 + WIN_H > V_ACTIVE) begin : g_err_win_y
    $error("vga_scan_gen: window extends past vertical active area");
  end
  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_err_total
    $error("vga_scan_gen: line or frame total exceeds 11-bit counters");
  end
  if (FETCH_LAT > 8) begin : g_err_lat
    $error("vga_scan_gen: FETCH_LAT above 8");
  end

  // Phase boundaries kept 12 bits wide so a total of exactly 2048 still compares correctly.
  localparam logic [11:0] H_ACT_END   = 12'(H_ACTIVE);
  localparam logic [11:0] H_FRONT_END = 12'(H_ACTIVE + H_FRONT);
  localparam logic [11:0] H_PULSE_END = 12'(H_ACTIVE + H_FRONT + H_PULSE);
  localparam logic [11:0] V_ACT_END   = 12'(V_ACTIVE);
  localparam logic [11:0] V_FRONT_END = 12'(V_ACTIVE + V_FRONT);
  localparam logic [11:0] V_PULSE_END = 12'(V_ACTIVE + V_FRONT + V_PULSE);
  localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST      = 11'(V_TOTAL - 1);
  localparam logic [11:0] WX_LO       = 12'(WIN_X0);
  localparam logic [11:0] WX_HI       = 12'(WIN_X0 + WIN_W);
  localparam logic [11:0] WY_LO       = 12'(WIN_Y0);
  localparam logic [11:0] WY_HI       = 12'(WIN_Y0 + WIN_H);

  localparam int unsigned CTL_W = 6;
  localparam logic [CTL_W-1:0] CTL_IDLE = {~HSYNC_POL, ~VSYNC_POL, 4'b0000};

  logic [10:0]          h_cnt, v_cnt;
  phase_e               h_phase, v_phase;
  logic                 in_win;
  logic [CTL_W-1:0]     ctl_s0, ctl_dly;
  logic [3*COLOR_W-1:0] pix_color;

  // Raster counters: line counter steps when the pixel counter wraps; both wrap together at frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  assign h_phase = phase_of({1'b0, h_cnt}, H_ACT_END, H_FRONT_END, H_PULSE_END);
  assign v_phase = phase_of({1'b0, v_cnt}, V_ACT_END, V_FRONT_END, V_PULSE_END);

  assign in_win = ({1'b0, h_cnt} >= WX_LO) && ({1'b0, h_cnt} < WX_HI) &&
                  ({1'b0, v_cnt} >= WY_LO) && ({1'b0, v_cnt} < WY_HI);

  assign next_valid = in_win;
  assign next_x     = in_win ? h_cnt - WX_LO[10:0] : 11'd0;
  assign next_y     = in_win ? v_cnt - WY_LO[10:0] : 11'd0;

  // Stage-0 control word: {hsync, vsync, de, in_win, frame_start, line_start}.
  assign ctl_s0 = {
    (h_phase == PULSE) ? HSYNC_POL : ~HSYNC_POL,
    (v_phase == PULSE) ? VSYNC_POL : ~VSYNC_POL,
    (h_phase == ACTIVE) && (v_phase == ACTIVE),
    in_win,
    (h_cnt == 11'd0) && (v_cnt == 11'd0),
    (h_cnt == 11'd0) && (v_phase == ACTIVE)
  };

  // Hold control back until the reader's colour for the same pixel arrives.
  vga_delay_line #(
    .DEPTH   (FETCH_LAT),
    .WIDTH   (CTL_W),
    .RST_VAL (CTL_IDLE)
  ) u_ctl_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (ctl_s0),
    .dout (ctl_dly)
  );

  // Colour source: reader data inside the window, border elsewhere in the active area, black in blanking.
  always_comb begin
    pix_color = '0;
    if (ctl_dly[2])      pix_color = color_in;
    else if (ctl_dly[3]) pix_color = BORDER_COLOR;
  end

  // Output register: everything reaches the pins on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      de          <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
    end else begin
      hsync       <= ctl_dly[5];
      vsync       <= ctl_dly[4];
      de          <= ctl_dly[3];
      frame_start <= ctl_dly[1];
      line_start  <= ctl_dly[0];
      red         <= pix_color[3*COLOR_W-1:2*COLOR_W];
      green       <= pix_color[2*COLOR_W-1:COLOR_W];
      blue        <= pix_color[COLOR_W-1:0];
    end
  end

endmodule

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench for vga_scan_gen on a small raster with random reader data and random resets.
// Latency: expects outputs FETCH_LAT+1 cycles after each counter position.
// Backpressure: none; the DUT produces one output every clock.
module tb_vga_scan_gen;

  localparam int HA = 20, HF = 3, HP = 4, HB = 5;
  localparam int VA = 10, VF = 2, VP = 3, VB = 4;
  localparam int HT = HA + HF + HP + HB;   // 32
  localparam int VT = VA + VF + VP + VB;   // 19
  localparam int FRAME = HT * VT;          // 608
  localparam int WX0 = 8, WW = 12, WY0 = 2, WH = 8;
  localparam int L = 3;
  localparam int CW = 8;
  localparam bit HPOL = 1'b1;
  localparam bit VPOL = 1'b0;
  localparam logic [23:0] BORDER = 24'h5A3C96;
  localparam int N_CYCLES = 6500;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic        ls;
    logic [23:0] rgb;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [3*CW-1:0] color_in;
  logic [10:0]   next_x, next_y;
  logic          next_valid;
  logic          hsync, vsync, de;
  logic [CW-1:0] red, green, blue;
  logic          frame_start, line_start;

  int   total = 0;
  int   bad = 0;
  bit   started = 0;
  int   idx = 0;
  int   fs_exp = 0, fs_got = 0;
  logic [23:0] salt;
  exp_t sbq[$];
  logic [22:0] hist[$];

  vga_scan_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_PULSE(HP), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_PULSE(VP), .V_BACK(VB),
    .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .COLOR_W(CW), .FETCH_LAT(L),
    .WIN_X0(WX0), .WIN_Y0(WY0), .WIN_W(WW), .WIN_H(WH),
    .BORDER_COLOR(BORDER)
  ) dut (
    .clk(clk), .rst(rst), .color_in(color_in),
    .next_x(next_x), .next_y(next_y), .next_valid(next_valid),
    .hsync(hsync), .vsync(vsync), .de(de),
    .red(red), .green(green), .blue(blue),
    .frame_start(frame_start), .line_start(line_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reader's memory contents as a function of window coordinates.
  function automatic logic [23:0] pix(int x, int y);
    logic [7:0] xb, yb;
    xb = 8'(x);
    yb = 8'(y);
    return {xb ^ salt[7:0], yb ^ salt[15:8], 8'(xb + yb) ^ salt[23:16]};
  endfunction

  function automatic exp_t idle_out();
    exp_t e;
    e = '0;
    e.hs = ~HPOL;
    e.vs = ~VPOL;
    return e;
  endfunction

  function automatic bit in_window(int x, int y);
    return (x >= WX0) && (x < WX0 + WW) && (y >= WY0) && (y < WY0 + WH);
  endfunction

  // Expected pin values for a raster position given as a linear index into the frame.
  function automatic exp_t model_out(int p);
    exp_t e;
    int x, y;
    bit act;
    x = p % HT;
    y = p / HT;
    act = (x < HA) && (y < VA);
    e.hs = (x >= HA + HF && x < HA + HF + HP) ? HPOL : ~HPOL;
    e.vs = (y >= VA + VF && y < VA + VF + VP) ? VPOL : ~VPOL;
    e.de = act;
    e.fs = (p == 0);
    e.ls = (x == 0) && (y < VA);
    if (in_window(x, y)) e.rgb = pix(x - WX0, y - WY0);
    else if (act)        e.rgb = BORDER;
    else                 e.rgb = 24'h0;
    return e;
  endfunction

  // Stimulus: reset schedule, reader emulation, and expected-response generation.
  initial begin
    int   rst_left;
    int   next_rst_at;
    int   x, y;
    logic [22:0] exp_next, got_next;
    logic [22:0] h;
    rst = 1'b1;
    color_in = '0;
    salt = 24'($urandom);
    rst_left = 2;
    next_rst_at = 1300 + $urandom_range(0, 200);
    for (int k = 0; k < N_CYCLES; k++) begin
      @(posedge clk);
      #1;
      if (rst) begin
        idx = 0;
        sbq.delete();
        for (int j = 0; j <= L; j++) sbq.push_back(idle_out());
        started = 1;
      end else begin
        idx = (idx + 1) % FRAME;
      end

      if (started) begin
        x = idx % HT;
        y = idx / HT;
        exp_next = in_window(x, y) ? {1'b1, 11'(x - WX0), 11'(y - WY0)} : 23'h0;
        got_next = {next_valid, next_x, next_y};
        total++;
        if (got_next !== exp_next) begin
          bad++;
          $display("FAIL next_coord cycle=%0d pos=(%0d,%0d) got=%h want=%h", k, x, y, got_next, exp_next);
        end
        sbq.push_back(model_out(idx));
      end

      // Reader: colour for the coordinate issued L cycles ago; junk when that request was invalid.
      hist.push_front({next_valid, next_x, next_y});
      if (hist.size() > L + 1) void'(hist.pop_back());
      h = (hist.size() == L + 1) ? hist[L] : 23'h0;
      if (h[22] === 1'b1) color_in = pix(int'(h[21:11]), int'(h[10:0]));
      else                color_in = 24'($urandom);

      if (rst_left > 0) begin
        rst = 1'b1;
        rst_left--;
      end else begin
        rst = 1'b0;
        if (k == next_rst_at) begin
          rst = 1'b1;
          rst_left = $urandom_range(0, 2);
          next_rst_at = k + $urandom_range(150, 1400);
        end
      end
    end

    total++;
    if (fs_got != fs_exp) begin
      bad++;
      $display("FAIL frame_start_count got=%0d want=%0d", fs_got, fs_exp);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Monitor: one output pixel per clock, compared against the oldest scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    logic [4:0] got_ctl, exp_ctl;
    logic [23:0] got_rgb;
    if (started) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty at time %0t got=empty want=entry", $time);
      end else begin
        e = sbq.pop_front();
        got_ctl = {hsync, vsync, de, frame_start, line_start};
        exp_ctl = {e.hs, e.vs, e.de, e.fs, e.ls};
        got_rgb = {red, green, blue};
        if (e.fs) fs_exp++;
        if (frame_start === 1'b1) fs_got++;
        if (got_ctl !== exp_ctl) begin
          bad++;
          $display("FAIL ctl {hs,vs,de,fs,ls} t=%0t got=%b want=%b", $time, got_ctl, exp_ctl);
        end
        total++;
        if (got_rgb !== e.rgb) begin
          bad++;
          $display("FAIL colour t=%0t got=%h want=%h", $time, got_rgb, e.rgb);
        end
      end
    end
  end

endmodule

// File: doc/vga_scan_gen.md
# vga_scan_gen

Parametrised VGA scan generator: the successor to the fixed 640x480 timing block in the display path. It produces hsync/vsync, a data-enable and window-relative pixel coordinates for a frame-buffer reader. It delays all sync and control outputs by a configurable fetch latency so colour returned by the reader lines up with sync, and it drives a border colour inside the active area but outside the window. Sits between the pixel-clock domain root and the VGA resistor DAC.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (cycles)
- H_PULSE, 96, hsync pulse width (cycles)
- H_BACK, 48, horizontal back porch (cycles)
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_PULSE, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync
- COLOR_W, 4, bits per colour channel
- FETCH_LAT, 1, cycles from next_x/next_y valid to matching color_in valid (0..8)
- WIN_X0, 76 / WIN_Y0, 100, window origin in active-area coordinates
- WIN_W, 488 / WIN_H, 280, window size
- BORDER_COLOR, 0, {R,G,B} packed, 3*COLOR_W bits
- clk  in  1  pixel clock (65 MHz max)
- rst  in  1  synchronous, active-high reset
- color_in  in  3*COLOR_W  {R,G,B} for coordinate issued FETCH_LAT cycles earlier
- next_x  out  11  window-relative x (0..WIN_W-1); 0 when next_valid=0
- next_y  out  11  window-relative y (0..WIN_H-1); 0 when next_valid=0
- next_valid  out  1  current counter position lies inside window
- hsync / vsync  out  1 each  sync to connector, polarity per parameter
- de  out  1  output pixel is in active area
- red / green / blue  out  COLOR_W each  pixel colour
- frame_start  out  1  one-cycle pulse with output pixel (0,0)
- line_start  out  1  one-cycle pulse with output pixel (0,v), every active line

## Operation
- h_cnt counts 0..H_TOTAL-1 (H_TOTAL = sum of H params), wraps to 0; v_cnt increments on h_cnt wrap, counts 0..V_TOTAL-1, wraps to 0.
- Phase order per axis: ACTIVE [0, ACTIVE-1], FRONT, PULSE, BACK; phase decoded from counter against cumulative constants.
- Sync asserted exactly during PULSE phase (hsync by h_cnt only, vsync by v_cnt only).
- in_win = h_cnt in [WIN_X0, WIN_X0+WIN_W-1] and v_cnt in [WIN_Y0, WIN_Y0+WIN_H-1]; next_x = h_cnt-WIN_X0, next_y = v_cnt-WIN_Y0 (combinational from counters).
- Stage 0 signals {hsync, vsync, de, in_win, frame_start, line_start} pass through a FETCH_LAT-deep delay, then one output register.
- Output colour: delayed in_win -> color_in; else delayed de -> BORDER_COLOR; else 0. Channels map R = color_in[3C-1:2C], G = [2C-1:C], B = [C-1:0].
- Elaboration error if WIN_X0+WIN_W > H_ACTIVE, WIN_Y0+WIN_H > V_ACTIVE, H_TOTAL or V_TOTAL > 2048, or FETCH_LAT > 8.

## Timing
- Reset: h_cnt = v_cnt = 0; all delay stages and output registers cleared; hsync = ~HSYNC_POL, vsync = ~VSYNC_POL, de = 0, colours 0, frame_start = line_start = 0.
- Output latency: FETCH_LAT+1 cycles from counter position to matching pins; colour is registered in the same cycle color_in is sampled.
- First cycle after rst deasserts: counters at (0,0); next_valid = 1 only if WIN_X0 = WIN_Y0 = 0.
- frame_start and line_start fire at FETCH_LAT+1 cycles after the counter reaches (0,0) / (0,v<V_ACTIVE).
- h/v wrap in the same cycle (last pixel of frame): both counters go to 0 together.
- rst mid-frame: counters restart at (0,0) next cycle; pipeline flushed, no partial sync pulse.
- Throughput: one pixel per clk; no stall input.

## Structure
- Package vga_pkg: timing constant sets VGA_640x480_60 and VGA_1024x768_60, a phase enum {ACTIVE, FRONT, PULSE, BACK}, and the H_TOTAL/V_TOTAL helper function.
- Sub-module vga_delay_line: parametrised depth/width shift register with per-bit reset value; depth 0 degenerates to a wire.

## Test plan
- Defaults, FETCH_LAT=1, run 2 frames -> hsync low for 96 cycles every 800; vsync low for 2 lines every 525; de high 640x480 per frame.
- Small params (H 8/2/2/2, V 4/1/1/1, window 2,1,4x2), echo color_in = {next_x,next_y} with FETCH_LAT=3 -> colour at output pixel (2,1) equals coordinate (0,0); pixel (0,0) = BORDER_COLOR.
- HSYNC_POL=1, VSYNC_POL=1 -> sync idle 0 after reset, pulses high with the same widths.
- Assert rst at h_cnt=300, v_cnt=200 for 1 cycle -> next cycle counters (0,0); outputs idle for FETCH_LAT+1 cycles; frame_start exactly FETCH_LAT+1 cycles after release.
- COLOR_W=8, color_in=24'hA1B2C3 in window -> red=A1, green=B2, blue=C3; during blanking all 0.
- frame_start counted over 3 frames -> exactly 3 pulses, each coincident with the first de-high cycle of the frame.
